// File: rtl/spart_tx_if.sv
// Bus-side signals of the SPART transmitter: byte write handshake, baud tick,
// serial line out and the transmit-buffer-ready status.
interface spart_tx_if;
  logic       enable;
  logic       wrt_tx;
  logic [7:0] data_in;
  logic       txd;
  logic       tbr;

  modport master (output enable, output wrt_tx, output data_in,
                  input txd, input tbr);
  modport slave  (input enable, input wrt_tx, input data_in,
                  output txd, output tbr);
endinterface

// File: rtl/spart_tx.sv
// SPART serial transmitter: one-entry holding register feeding an 8N1 shifter
// (LSB first), bit timing paced by the oversampling enable tick.
//
// state | meaning
// IDLE  | line high, waiting for a full holding register
// START | start bit (low) for TICKS_PER_BIT ticks
// DATA  | eight data bits, shift[0] on the line
// STOP  | stop bit (high); may hand straight over to the next START
module spart_tx #(
  parameter int TICKS_PER_BIT = 16
) (
  input logic      clk,
  input logic      rst_n,
  spart_tx_if.slave bus
);

  localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [7:0]    hold;
  logic          hold_empty;
  logic          txd_r;
  logic          bit_end;
  logic          xfer;

  assign bit_end = bus.enable && (tick_cnt == TICK_LAST);
  // Transfer may also happen on the last stop-bit tick, giving gapless frames.
  assign xfer    = !hold_empty && ((state == IDLE) || ((state == STOP) && bit_end));

  assign bus.txd = txd_r;
  assign bus.tbr = hold_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      hold       <= '0;
      hold_empty <= 1'b1;
      txd_r      <= 1'b1;
    end else begin
      if (bus.wrt_tx && hold_empty) begin
        hold       <= bus.data_in;
        hold_empty <= 1'b0;
      end

      case (state)
        IDLE: txd_r <= 1'b1;
        START: begin
          if (bus.enable) begin
            if (bit_end) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= DATA;
              txd_r    <= shift[0];
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        DATA: begin
          if (bus.enable) begin
            if (bit_end) begin
              tick_cnt <= '0;
              shift    <= {1'b0, shift[7:1]};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= STOP;
                txd_r <= 1'b1;
              end else begin
                txd_r <= shift[1];
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        STOP: begin
          if (bus.enable) begin
            if (bit_end) begin
              tick_cnt <= '0;
              state    <= IDLE;
              txd_r    <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Placed last so a transfer overrides the per-state updates above.
      if (xfer) begin
        shift      <= hold;
        hold_empty <= 1'b1;
        state      <= START;
        tick_cnt   <= '0;
        txd_r      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spart_tx.sv
// Bench for spart_tx: two instances (16 and 4 ticks per bit) compared every
// cycle against a frame-position model, plus directed frame decodes.
module tb_spart_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spart_tx_if bus_a ();
  spart_tx_if bus_b ();

  spart_tx #(.TICKS_PER_BIT(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  spart_tx #(.TICKS_PER_BIT(4))  dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  int nerr = 0;
  int nchk = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is 10*tpb enable ticks; position within it selects the bit.
  typedef struct {
    bit         busy;
    int         pos;
    logic [7:0] cur;
    bit         hf;
    logic [7:0] hold;
  } mdl_t;

  function automatic mdl_t step(mdl_t m, bit wrt, logic [7:0] d, bit en, int tpb);
    mdl_t n = m;
    bit fin = m.busy && en && (m.pos == 10 * tpb - 1);
    if (m.busy && en) n.pos = m.pos + 1;
    if (fin) n.busy = 1'b0;
    if (m.hf && (!m.busy || fin)) begin
      n.busy = 1'b1;
      n.pos  = 0;
      n.cur  = m.hold;
      n.hf   = 1'b0;
    end
    if (wrt && !m.hf) begin
      n.hf   = 1'b1;
      n.hold = d;
    end
    return n;
  endfunction

  function automatic logic exp_txd(mdl_t m, int tpb);
    int idx;
    logic [7:0] c;
    if (!m.busy) return 1'b1;
    idx = m.pos / tpb;
    c = m.cur;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return c[idx-1];
    return 1'b1;
  endfunction

  mdl_t ma, mb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= '{busy: 1'b0, pos: 0, cur: 8'h00, hf: 1'b0, hold: 8'h00};
      mb <= '{busy: 1'b0, pos: 0, cur: 8'h00, hf: 1'b0, hold: 8'h00};
    end else begin
      ma <= step(ma, bus_a.wrt_tx, bus_a.data_in, bus_a.enable, 16);
      mb <= step(mb, bus_b.wrt_tx, bus_b.data_in, bus_b.enable, 4);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("txd_a_model", 32'(bus_a.txd), 32'(exp_txd(ma, 16)));
      chk("tbr_a_model", 32'(bus_a.tbr), 32'(!ma.hf));
      chk("txd_b_model", 32'(bus_b.txd), 32'(exp_txd(mb, 4)));
      chk("tbr_b_model", 32'(bus_b.tbr), 32'(!mb.hf));
    end
  end

  // Enable: period N (one tick every N cycles) or 0 for random 50%.
  int en_per_a = 1;
  int en_per_b = 1;
  int cyc = 0;
  always @(negedge clk) begin
    cyc++;
    bus_a.enable = (en_per_a == 0) ? 1'($urandom_range(0, 1)) : 1'((cyc % en_per_a) == 0);
    bus_b.enable = (en_per_b == 0) ? 1'($urandom_range(0, 1)) : 1'((cyc % en_per_b) == 0);
  end

  function automatic logic get_txd(int sel);
    return (sel == 0) ? bus_a.txd : bus_b.txd;
  endfunction

  function automatic logic get_tbr(int sel);
    return (sel == 0) ? bus_a.tbr : bus_b.tbr;
  endfunction

  task automatic set_wr(input int sel, input logic w, input logic [7:0] d);
    if (sel == 0) begin
      bus_a.wrt_tx = w;
      bus_a.data_in = d;
    end else begin
      bus_b.wrt_tx = w;
      bus_b.data_in = d;
    end
  endtask

  // Called at a negedge; returns at the negedge following the sampling edge.
  task automatic do_write(input int sel, input logic [7:0] d);
    set_wr(sel, 1'b1, d);
    @(negedge clk);
    set_wr(sel, 1'b0, 8'h00);
  endtask

  // Called at the first start-bit negedge; samples mid-bit and checks the frame.
  task automatic decode(input int sel, input int len, input logic [7:0] exp_b, input string tag);
    logic [9:0] f;
    logic [9:0] want;
    want = {1'b1, exp_b, 1'b0};
    repeat (len / 2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      f[i] = get_txd(sel);
      if (i < 9) repeat (len) @(negedge clk);
    end
    chk(tag, 32'(f), 32'(want));
    repeat (len) @(negedge clk);
  endtask

  task automatic write_and_decode(input int sel, input logic [7:0] d, input int len, input string tag);
    do_write(sel, d);
    chk({tag, "_tbr_e0"}, 32'(get_tbr(sel)), 32'd0);
    @(negedge clk);
    chk({tag, "_start_e1"}, 32'(get_txd(sel)), 32'd0);
    chk({tag, "_tbr_e1"}, 32'(get_tbr(sel)), 32'd1);
    decode(sel, len, d, {tag, "_frame"});
  endtask

  typedef struct {
    logic [7:0] data;
    int         en_per;
    int         bit_cycles;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{data: 8'hA5, en_per: 1, bit_cycles: 16};
    vecs[1] = '{data: 8'h3C, en_per: 1, bit_cycles: 16};
    vecs[2] = '{data: 8'h81, en_per: 2, bit_cycles: 32};
    vecs[3] = '{data: 8'hA5, en_per: 4, bit_cycles: 64};
    vecs[4] = '{data: 8'h6E, en_per: 4, bit_cycles: 64};

    set_wr(0, 1'b0, 8'h00);
    set_wr(1, 1'b0, 8'h00);
    bus_a.enable = 1'b0;
    bus_b.enable = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_txd", 32'(bus_a.txd), 32'd1);
    chk("reset_tbr", 32'(bus_a.tbr), 32'd1);
    rst_n = 1'b1;
    chk_on = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      en_per_a = vecs[i].en_per;
      @(negedge clk);
      write_and_decode(0, vecs[i].data, vecs[i].bit_cycles, $sformatf("vec%0d", i));
    end
    en_per_a = 1;

    // Back-to-back: second byte written as soon as tbr returns high.
    @(negedge clk);
    do_write(0, 8'h00);
    @(negedge clk);
    do_write(0, 8'hFF);
    repeat (158) @(negedge clk);
    chk("b2b_stop_txd", 32'(bus_a.txd), 32'd1);
    chk("b2b_stop_tbr", 32'(bus_a.tbr), 32'd0);
    @(negedge clk);
    chk("b2b_start_txd", 32'(bus_a.txd), 32'd0);
    chk("b2b_start_tbr", 32'(bus_a.tbr), 32'd1);
    decode(0, 16, 8'hFF, "b2b_frame2");

    // Write while full: 0x81 must be dropped.
    @(negedge clk);
    do_write(0, 8'h3C);
    @(negedge clk);
    do_write(0, 8'h5A);
    do_write(0, 8'h81);
    chk("full_tbr", 32'(bus_a.tbr), 32'd0);
    repeat (330) @(negedge clk);
    chk("full_idle_txd", 32'(bus_a.txd), 32'd1);
    chk("full_idle_tbr", 32'(bus_a.tbr), 32'd1);

    // Reset during data bit 3 of 0x0F.
    @(negedge clk);
    do_write(0, 8'h0F);
    @(negedge clk);
    repeat (72) @(negedge clk);
    chk("mid_bit3_txd", 32'(bus_a.txd), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_txd", 32'(bus_a.txd), 32'd1);
    chk("rst_async_tbr", 32'(bus_a.tbr), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_idle", 32'(bus_a.txd), 32'd1);
    write_and_decode(0, 8'h55, 16, "post_rst");

    // Four ticks per bit.
    en_per_b = 1;
    @(negedge clk);
    write_and_decode(1, 8'hC3, 4, "tpb4");

    // Random traffic on both instances.
    en_per_a = 0;
    en_per_b = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      set_wr(0, 1'($urandom_range(0, 15) == 0), 8'($urandom));
      set_wr(1, 1'($urandom_range(0, 7) == 0), 8'($urandom));
    end
    @(negedge clk);
    set_wr(0, 1'b0, 8'h00);
    set_wr(1, 1'b0, 8'h00);
    en_per_a = 1;
    en_per_b = 1;
    repeat (400) @(negedge clk);
    chk("final_idle_a", 32'({bus_a.txd, bus_a.tbr}), 32'd3);
    chk("final_idle_b", 32'({bus_b.txd, bus_b.tbr}), 32'd3);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
